filter_3x3_stream: RTL and testbench

//  Streaming 3x3 convolution filter for camera frames, raster order, one pixel per accepted beat.

---
 rtl/filter_3x3_stream_pkg.sv | 74 +++++++
 rtl/filter_3x3_stream_line_buffer_ram.sv | 28 ++
 rtl/filter_3x3_stream.sv | 192 +++++++++++++++++++
 tb/tb_filter_3x3_stream.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_3x3_stream_pkg.sv
// Shared constants and helpers for the streaming 3x3 filter: RGB565 channel
// layout, per-channel width/offset lookup, accumulator width and clamping.
package filter_3x3_stream_pkg;

    localparam int R_LSB     = 11;
    localparam int R_W       = 5;
    localparam int G_LSB     = 5;
    localparam int G_W       = 6;
    localparam int B_LSB     = 0;
    localparam int B_W       = 5;
    localparam int SUM_GUARD = 12;

    // Number of independently filtered channels in a pixel.
    function automatic int num_channels(input int mode);
        int n;
        if (mode == 1) begin
            n = 3;
        end else begin
            n = 1;
        end
        return n;
    endfunction

    // Bit width of channel ch (R, G, B order in RGB565 mode).
    function automatic int ch_width(input int mode, input int ch, input int pix_w);
        int w;
        if (mode == 1) begin
            case (ch)
                0:       w = R_W;
                1:       w = G_W;
                default: w = B_W;
            endcase
        end else begin
            w = pix_w;
        end
        return w;
    endfunction

    // Bit offset of channel ch inside the pixel word.
    function automatic int ch_lsb(input int mode, input int ch);
        int l;
        if (mode == 1) begin
            case (ch)
                0:       l = R_LSB;
                1:       l = G_LSB;
                default: l = B_LSB;
            endcase
        end else begin
            l = 0;
        end
        return l;
    endfunction

    // Signed accumulator width for a channel of cw bits.
    function automatic int sum_width(input int cw);
        return cw + SUM_GUARD;
    endfunction

    // Clamp a signed value into the unsigned range [0, 2^cw-1].
    function automatic logic [31:0] saturate(input logic signed [31:0] value, input int cw);
        logic signed [31:0] max_v;
        logic [31:0]        result;
        max_v = (32'sd1 <<< cw) - 32'sd1;
        if (value < 32'sd0) begin
            result = 32'd0;
        end else if (value > max_v) begin
            result = max_v;
        end else begin
            result = value;
        end
        return result;
    endfunction

endpackage

// File: rtl/filter_3x3_stream_line_buffer_ram.sv
// One line of pixel history: simple dual-port RAM with a combinational read
// port, so a read and a write to the same address in one cycle return the old
// contents (read-before-write).
module filter_3x3_stream_line_buffer_ram #(
    parameter int DEPTH  = 240,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Write port: store the new pixel for this column.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_r[rd_addr];

endmodule

// File: rtl/filter_3x3_stream.sv
// Streaming 3x3 convolution over raster-order frames with two line buffers,
// valid/ready flow control, SOF resync and per-channel saturated arithmetic.
module filter_3x3_stream
    import filter_3x3_stream_pkg::*;
#(
    parameter int LINE_WIDTH = 240,
    parameter int NUM_LINES  = 320,
    parameter int PIX_W      = 16,
    parameter int MODE       = 1,
    parameter int WA1        = -4,
    parameter int WB3        = 1,
    parameter int WA3        = 0,
    parameter int DIV_SHIFT  = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_valid,
    input  logic             in_sof,
    output logic             in_ready,
    output logic [PIX_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sof,
    output logic             out_eol,
    output logic             sof_err
);

    localparam int XW  = $clog2(LINE_WIDTH);
    localparam int YW  = $clog2(NUM_LINES);
    localparam int NCH = num_channels(MODE);

    logic [XW-1:0]    x_r, cur_x_s;
    logic [YW-1:0]    y_r, cur_y_s;
    logic             advance_s, accept_s, at_origin_s, last_x_s, last_y_s, produce_s;
    logic             lb_wr_s;
    logic [PIX_W-1:0] lb0_rd_s, lb1_rd_s;
    // Window history: row 0 = line y-2, row 1 = line y-1, row 2 = line y;
    // column 0 = x-2, column 1 = x-1 relative to the beat being presented.
    logic [PIX_W-1:0] win_r [3][2];
    logic [PIX_W-1:0] new_col_s [3];
    logic [PIX_W-1:0] tap_s [9];
    logic [PIX_W-1:0] result_s;
    logic             out_valid_r, out_sof_r, out_eol_r, sof_err_r;
    logic [PIX_W-1:0] out_data_r;

    // Handshake, SOF-resync position and interior-pixel decode for this beat.
    always_comb begin
        advance_s   = !out_valid_r || out_ready;
        accept_s    = in_valid && advance_s;
        at_origin_s = (x_r == '0) && (y_r == '0);
        if (in_sof) begin
            cur_x_s = '0;
            cur_y_s = '0;
        end else begin
            cur_x_s = x_r;
            cur_y_s = y_r;
        end
        last_x_s  = (cur_x_s == XW'(LINE_WIDTH - 1));
        last_y_s  = (cur_y_s == YW'(NUM_LINES - 1));
        produce_s = accept_s && (cur_x_s >= XW'(2)) && (cur_y_s >= YW'(2));
        lb_wr_s   = accept_s && reset;
    end

    assign in_ready = advance_s;

    // Raster position counters; an accepted SOF restarts them at (0,0).
    always_ff @(posedge clk) begin
        if (!reset) begin
            x_r <= '0;
            y_r <= '0;
        end else if (accept_s) begin
            if (last_x_s) begin
                x_r <= '0;
                y_r <= last_y_s ? '0 : cur_y_s + YW'(1);
            end else begin
                x_r <= cur_x_s + XW'(1);
                y_r <= cur_y_s;
            end
        end
    end

    filter_3x3_stream_line_buffer_ram #(
        .DEPTH (LINE_WIDTH),
        .DATA_W(PIX_W),
        .ADDR_W(XW)
    ) u_lb0 (
        .clk    (clk),
        .wr_en  (lb_wr_s),
        .wr_addr(cur_x_s),
        .wr_data(in_data),
        .rd_addr(cur_x_s),
        .rd_data(lb0_rd_s)
    );

    filter_3x3_stream_line_buffer_ram #(
        .DEPTH (LINE_WIDTH),
        .DATA_W(PIX_W),
        .ADDR_W(XW)
    ) u_lb1 (
        .clk    (clk),
        .wr_en  (lb_wr_s),
        .wr_addr(cur_x_s),
        .wr_data(lb0_rd_s),
        .rd_addr(cur_x_s),
        .rd_data(lb1_rd_s)
    );

    assign new_col_s[0] = lb1_rd_s;
    assign new_col_s[1] = lb0_rd_s;
    assign new_col_s[2] = in_data;

    // Shift the window one column left on every accepted beat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < 3; r++) begin
                win_r[r][0] <= '0;
                win_r[r][1] <= '0;
            end
        end else if (accept_s) begin
            for (int r = 0; r < 3; r++) begin
                win_r[r][0] <= win_r[r][1];
                win_r[r][1] <= new_col_s[r];
            end
        end
    end

    // Assemble the full 3x3 neighbourhood: stored columns plus the incoming one.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            tap_s[r*3 + 0] = win_r[r][0];
            tap_s[r*3 + 1] = win_r[r][1];
            tap_s[r*3 + 2] = new_col_s[r];
        end
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        localparam int CW  = ch_width(MODE, g, PIX_W);
        localparam int LSB = ch_lsb(MODE, g);
        localparam int SW  = sum_width(CW);
        localparam logic signed [SW-1:0] WA1_S = SW'(WA1);
        localparam logic signed [SW-1:0] WB3_S = SW'(WB3);
        localparam logic signed [SW-1:0] WA3_S = SW'(WA3);

        logic signed [SW-1:0] ext_s [9];
        logic signed [SW-1:0] sum_s, res_s;

        for (genvar k = 0; k < 9; k++) begin : g_tap
            assign ext_s[k] = $signed(SW'(tap_s[k][LSB +: CW]));
        end

        // Index 4 is the centre, 1/3/5/7 the edge neighbours, 0/2/6/8 the corners.
        assign sum_s = WA1_S * ext_s[4]
                     + WB3_S * (ext_s[1] + ext_s[3] + ext_s[5] + ext_s[7])
                     + WA3_S * (ext_s[0] + ext_s[2] + ext_s[6] + ext_s[8]);
        assign res_s = sum_s >>> DIV_SHIFT;
        assign result_s[LSB +: CW] = CW'(saturate(32'(res_s), CW));
    end

    // Output register; frozen while the downstream stalls a valid beat.
    always_ff @(posedge clk) begin
        if (!reset) begin
            out_valid_r <= 1'b0;
            out_sof_r   <= 1'b0;
            out_eol_r   <= 1'b0;
            out_data_r  <= '0;
        end else if (advance_s) begin
            out_valid_r <= produce_s;
            out_sof_r   <= produce_s && (cur_x_s == XW'(2)) && (cur_y_s == YW'(2));
            out_eol_r   <= produce_s && last_x_s;
            if (produce_s) begin
                out_data_r <= result_s;
            end
        end
    end

    // One-cycle flag for an SOF that arrives away from (0,0).
    always_ff @(posedge clk) begin
        if (!reset) begin
            sof_err_r <= 1'b0;
        end else begin
            sof_err_r <= accept_s && in_sof && !at_origin_s;
        end
    end

    assign out_valid = out_valid_r;
    assign out_sof   = out_sof_r;
    assign out_eol   = out_eol_r;
    assign out_data  = out_data_r;
    assign sof_err   = sof_err_r;

endmodule

// File: tb/tb_filter_3x3_stream.sv
// Bench for filter_3x3_stream: four differently configured instances share one
// 8x6 input stream; a frame-image model predicts every output cycle.
`timescale 1ns/1ps
module tb_filter_3x3_stream;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int NI = 4;

    logic        clk, reset, in_valid, in_sof, out_ready;
    logic [15:0] in_data;
    logic [NI-1:0] rdy, ov, osof, oeol, oerr;
    logic [7:0]  od_g0, od_g1, od_g3;
    logic [15:0] od_rgb;

    int n_checks, n_fail;
    bit chk_en;
    logic [15:0] img [H][W];
    int mx, my;
    logic exp_valid, exp_sof, exp_eol, exp_err;
    logic [15:0] exp_data [NI];
    logic [15:0] cap [NI][256];
    int ocnt [NI], sofc [NI], eolc [NI], errc [NI];

    filter_3x3_stream #(.LINE_WIDTH(W), .NUM_LINES(H), .PIX_W(8), .MODE(0),
        .WA1(-4), .WB3(1), .WA3(0), .DIV_SHIFT(0)) u_g0 (
        .clk(clk), .reset(reset), .in_data(in_data[7:0]), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(rdy[0]), .out_data(od_g0), .out_valid(ov[0]), .out_ready(out_ready),
        .out_sof(osof[0]), .out_eol(oeol[0]), .sof_err(oerr[0]));
    filter_3x3_stream #(.LINE_WIDTH(W), .NUM_LINES(H), .PIX_W(8), .MODE(0),
        .WA1(4), .WB3(-1), .WA3(0), .DIV_SHIFT(0)) u_g1 (
        .clk(clk), .reset(reset), .in_data(in_data[7:0]), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(rdy[1]), .out_data(od_g1), .out_valid(ov[1]), .out_ready(out_ready),
        .out_sof(osof[1]), .out_eol(oeol[1]), .sof_err(oerr[1]));
    filter_3x3_stream #(.LINE_WIDTH(W), .NUM_LINES(H), .PIX_W(16), .MODE(1),
        .WA1(5), .WB3(-1), .WA3(0), .DIV_SHIFT(0)) u_rgb (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(rdy[2]), .out_data(od_rgb), .out_valid(ov[2]), .out_ready(out_ready),
        .out_sof(osof[2]), .out_eol(oeol[2]), .sof_err(oerr[2]));
    filter_3x3_stream #(.LINE_WIDTH(W), .NUM_LINES(H), .PIX_W(8), .MODE(0),
        .WA1(8), .WB3(-1), .WA3(-1), .DIV_SHIFT(1)) u_g3 (
        .clk(clk), .reset(reset), .in_data(in_data[7:0]), .in_valid(in_valid), .in_sof(in_sof),
        .in_ready(rdy[3]), .out_data(od_g3), .out_valid(ov[3]), .out_ready(out_ready),
        .out_sof(osof[3]), .out_eol(oeol[3]), .sof_err(oerr[3]));

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int p_mode(input int i);
        return (i == 2) ? 1 : 0;
    endfunction
    function automatic int p_wa1(input int i);
        case (i) 0: return -4; 1: return 4; 2: return 5; default: return 8; endcase
    endfunction
    function automatic int p_wb3(input int i);
        return (i == 0) ? 1 : -1;
    endfunction
    function automatic int p_wa3(input int i);
        return (i == 3) ? -1 : 0;
    endfunction
    function automatic int p_ds(input int i);
        return (i == 3) ? 1 : 0;
    endfunction

    function automatic logic [15:0] od_of(input int i);
        case (i)
            0: return {8'h00, od_g0};
            1: return {8'h00, od_g1};
            2: return od_rgb;
            default: return {8'h00, od_g3};
        endcase
    endfunction

    function automatic int chan(input logic [15:0] p, input int lsb, input int cw);
        int v;
        v = int'(p);
        return (v >> lsb) & ((1 << cw) - 1);
    endfunction

    // Filtered value of pixel (cx,cy) of the stored frame for instance inst.
    function automatic logic [15:0] model_out(input int inst, input int cx, input int cy);
        int nch, cw, lsb, s;
        logic [15:0] r;
        r = 16'h0000;
        nch = (p_mode(inst) == 1) ? 3 : 1;
        for (int ch = 0; ch < nch; ch++) begin
            if (p_mode(inst) == 1) begin
                cw  = (ch == 1) ? 6 : 5;
                lsb = (ch == 0) ? 11 : ((ch == 1) ? 5 : 0);
            end else begin
                cw  = 8;
                lsb = 0;
            end
            s = p_wa1(inst) * chan(img[cy][cx], lsb, cw)
              + p_wb3(inst) * (chan(img[cy-1][cx], lsb, cw) + chan(img[cy+1][cx], lsb, cw)
                             + chan(img[cy][cx-1], lsb, cw) + chan(img[cy][cx+1], lsb, cw))
              + p_wa3(inst) * (chan(img[cy-1][cx-1], lsb, cw) + chan(img[cy-1][cx+1], lsb, cw)
                             + chan(img[cy+1][cx-1], lsb, cw) + chan(img[cy+1][cx+1], lsb, cw));
            s = s >>> p_ds(inst);
            if (s < 0) s = 0;
            if (s > (1 << cw) - 1) s = (1 << cw) - 1;
            r = r | 16'(s << lsb);
        end
        return r;
    endfunction

    function automatic logic [15:0] pix(input int kind, input int x, input int y);
        case (kind)
            0: return 16'd100;
            1: return (x == 3 && y == 3) ? 16'd200 : 16'd0;
            2: return 16'hFFFF;
            3: return (x == 3 && y == 3) ? 16'hF800 : 16'h0000;
            default: return 16'((x * 37 + y * 101 + x * y * 13 + 5) * 73);
        endcase
    endfunction

    task automatic chk(input string name, input int inst, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s inst=%0d got=%0h exp=%0h t=%0t", name, inst, got, exp, $time);
        end
    endtask

    // Per-cycle checker plus the frame model that predicts the next edge.
    task automatic compare_loop();
        logic adv, acc, prod, hold_q;
        logic [15:0] hold_d [NI];
        hold_q = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                for (int i = 0; i < NI; i++) begin
                    chk("in_ready", i, rdy[i], !exp_valid || out_ready);
                    chk("out_valid", i, ov[i], exp_valid);
                    chk("sof_err", i, oerr[i], exp_err);
                    if (exp_valid) begin
                        chk("out_data", i, od_of(i), exp_data[i]);
                        chk("out_sof", i, osof[i], exp_sof);
                        chk("out_eol", i, oeol[i], exp_eol);
                    end
                    if (hold_q) chk("hold_data", i, od_of(i), hold_d[i]);
                    if (ov[i] && out_ready) begin
                        if (ocnt[i] < 256) cap[i][ocnt[i]] = od_of(i);
                        ocnt[i]++;
                        if (osof[i]) sofc[i]++;
                        if (oeol[i]) eolc[i]++;
                    end
                    if (oerr[i]) errc[i]++;
                    hold_d[i] = od_of(i);
                end
                hold_q = ov[0] && !out_ready;
            end
            if (!reset) begin
                exp_valid = 1'b0; exp_sof = 1'b0; exp_eol = 1'b0; exp_err = 1'b0;
                mx = 0; my = 0;
            end else begin
                adv  = !exp_valid || out_ready;
                acc  = in_valid && adv;
                prod = 1'b0;
                exp_err = acc && in_sof && (mx != 0 || my != 0);
                if (acc) begin
                    if (in_sof) begin mx = 0; my = 0; end
                    img[my][mx] = in_data;
                    prod = (mx >= 2) && (my >= 2);
                end
                if (adv) begin
                    exp_valid = prod;
                    if (prod) begin
                        for (int i = 0; i < NI; i++) exp_data[i] = model_out(i, mx - 1, my - 1);
                        exp_sof = (mx == 2) && (my == 2);
                        exp_eol = (mx == W - 1);
                    end
                end
                if (acc) begin
                    if (mx == W - 1) begin
                        mx = 0;
                        my = (my == H - 1) ? 0 : my + 1;
                    end else begin
                        mx++;
                    end
                end
            end
        end
    endtask

    task automatic send_beat(input logic [15:0] d, input logic sof);
        int tries;
        tries = 0;
        in_valid = 1'b1; in_data = d; in_sof = sof;
        forever begin
            @(negedge clk);
            if (rdy[0]) begin
                @(posedge clk); #1;
                break;
            end
            tries++;
            if (tries > 100) begin
                n_checks++; n_fail++;
                $display("FAIL accept_timeout got=%0d cycles exp=accept", tries);
                @(posedge clk); #1;
                break;
            end
        end
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic send_range(input int kind, input int i0, input int i1);
        for (int i = i0; i < i1; i++) send_beat(pix(kind, i % W, i / W), i == 0);
    endtask

    task automatic drain();
        repeat (4) @(posedge clk);
        #1;
    endtask

    int b, cnt;
    logic [15:0] held;

    initial begin
        n_checks = 0; n_fail = 0; chk_en = 0;
        reset = 1'b0; in_valid = 1'b0; in_sof = 1'b0; in_data = 16'h0000; out_ready = 1'b1;
        mx = 0; my = 0; exp_valid = 1'b0; exp_sof = 1'b0; exp_eol = 1'b0; exp_err = 1'b0;
        for (int i = 0; i < NI; i++) begin
            ocnt[i] = 0; sofc[i] = 0; eolc[i] = 0; errc[i] = 0; exp_data[i] = 16'h0000;
        end
        fork compare_loop(); join_none
        fork begin #400000; $display("FAIL global_timeout got=running exp=finished"); $fatal(1); end join_none
        repeat (3) @(posedge clk);
        #1 reset = 1'b1; chk_en = 1;
        @(negedge clk);
        chk("rst_out_data", 0, od_of(0), 16'h0000);
        chk("rst_out_valid", 0, ov[0], 1'b0);
        chk("rst_in_ready", 0, rdy[0], 1'b1);
        @(posedge clk); #1;

        // Constant gray 100 with default weights: flat field filters to 0.
        b = ocnt[0];
        send_range(0, 0, W * H); drain();
        chk("t1_count", 0, ocnt[0] - b, 24);
        chk("t1_sof_count", 0, sofc[0], 1);
        chk("t1_eol_count", 0, eolc[0], 4);
        cnt = 0;
        for (int k = 0; k < 24; k++) if (cap[0][b + k] == 16'h0000) cnt++;
        chk("t1_all_zero", 0, cnt, 24);

        // Single 200 pixel at (3,3), centre weight 4, edge weight -1.
        b = ocnt[1];
        send_range(1, 0, W * H); drain();
        chk("t2_centre", 1, cap[1][b + 14], 16'd255);
        chk("t2_west", 1, cap[1][b + 13], 16'd0);
        chk("t2_east", 1, cap[1][b + 15], 16'd0);
        chk("t2_north", 1, cap[1][b + 8], 16'd0);
        chk("t2_south", 1, cap[1][b + 20], 16'd0);
        cnt = 0;
        for (int k = 0; k < 24; k++) if (cap[1][b + k] != 16'h0000) cnt++;
        chk("t2_nonzero", 1, cnt, 1);

        // RGB565: white field stays white; lone red pixel saturates to 31.
        b = ocnt[2];
        send_range(2, 0, W * H); drain();
        cnt = 0;
        for (int k = 0; k < 24; k++) if (cap[2][b + k] == 16'hFFFF) cnt++;
        chk("t3_white", 2, cnt, 24);
        b = ocnt[2];
        send_range(3, 0, W * H); drain();
        chk("t3_red_centre", 2, cap[2][b + 14], 16'hF800);
        chk("t3_red_west", 2, cap[2][b + 13], 16'h0000);

        // Ramp with a 5-cycle downstream stall in the middle of line 2.
        b = ocnt[0];
        fork
            send_range(4, 0, W * H);
            begin
                repeat (22) @(posedge clk);
                #1 out_ready = 1'b0;
                held = od_of(0);
                repeat (5) begin
                    @(negedge clk);
                    chk("t4_stall_ready", 0, rdy[0], 1'b0);
                    chk("t4_stall_data", 0, od_of(0), held);
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();
        chk("t4_count", 0, ocnt[0] - b, 24);

        // SOF arriving at (4,2) restarts the frame and flags once.
        b = errc[0];
        send_range(4, 0, 20);
        send_range(4, 0, 1);
        cnt = ocnt[0];
        send_range(4, 1, W * H); drain();
        chk("t5_err_pulses", 0, errc[0] - b, 1);
        chk("t5_count", 0, ocnt[0] - cnt, 24);

        // Reset for one cycle mid-frame, then a clean frame.
        send_range(4, 0, 30);
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("t6_valid_after_rst", 0, ov[0], 1'b0);
        chk("t6_ready_after_rst", 0, rdy[0], 1'b1);
        @(posedge clk); #1;
        b = ocnt[3];
        send_range(1, 0, W * H); drain();
        chk("t6_count", 3, ocnt[3] - b, 24);
        chk("t6_g3_centre", 3, cap[3][b + 14], 16'd255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
